// File: rtl/systolic_drain.sv
`default_nettype none
// +------------------------------------------------------------------+
// | systolic_drain: deskews the array's bottom-row psums into 128-bit |
// | rows, buffers them in a FIFO and hands them out over valid/ready. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module systolic_drain #(
  parameter int DEPTH  = 8,
  parameter int ROWS_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       sys_data_out_41,
  input  logic [31:0]       sys_data_out_42,
  input  logic [31:0]       sys_data_out_43,
  input  logic [31:0]       sys_data_out_44,
  input  logic              sys_valid_out_41,
  input  logic              sys_valid_out_42,
  input  logic              sys_valid_out_43,
  input  logic              sys_valid_out_44,
  input  logic              drain_start,
  input  logic [ROWS_W-1:0] drain_rows,
  output logic [127:0]      out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              skew_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ROWS_W-1:0] rows_target_q, rows_target_d;
  logic [ROWS_W-1:0] row_cnt_q, row_cnt_d;
  logic              overflow_q, overflow_d;
  logic              skew_err_q, skew_err_d;
  logic              done_q, done_d;

  // Column k is delayed (4-k) stages; column 4 is used straight off the port.
  logic [2:0][31:0]  c1_dat_q, c1_dat_d;
  logic [2:0]        c1_vld_q, c1_vld_d;
  logic [1:0][31:0]  c2_dat_q, c2_dat_d;
  logic [1:0]        c2_vld_q, c2_vld_d;
  logic [31:0]       c3_dat_q, c3_dat_d;
  logic              c3_vld_q, c3_vld_d;

  logic [DEPTH-1:0][128:0] mem_q, mem_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [3:0]        aligned_vld;
  logic [127:0]      aligned_dat;
  logic              accepting;
  logic              row_form;
  logic              row_skew;
  logic              row_last;
  logic              pop;
  logic              push;
  logic              drop;

  always_comb begin
    c1_dat_d = {c1_dat_q[1:0], sys_data_out_41};
    c1_vld_d = {c1_vld_q[1:0], sys_valid_out_41};
    c2_dat_d = {c2_dat_q[0], sys_data_out_42};
    c2_vld_d = {c2_vld_q[0], sys_valid_out_42};
    c3_dat_d = sys_data_out_43;
    c3_vld_d = sys_valid_out_43;
  end

  assign aligned_vld = {sys_valid_out_44, c3_vld_q, c2_vld_q[1], c1_vld_q[2]};
  assign aligned_dat = {sys_data_out_44, c3_dat_q, c2_dat_q[1], c1_dat_q[2]};

  // Once the target count is reached no further rows are taken, even in the
  // single COLLECT cycle before the FSM moves on.
  assign accepting = (state_q == ST_COLLECT) && (row_cnt_q != rows_target_q);
  assign row_form  = accepting && (&aligned_vld);
  assign row_skew  = accepting && (|aligned_vld) && !(&aligned_vld);
  assign row_last  = ((row_cnt_q + ROWS_W'(1)) == rows_target_q);

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = row_form && ((count_q < FULL_CNT) || pop);
  assign drop      = row_form && !push;

  assign out_data  = out_valid ? mem_q[rd_ptr_q][127:0] : 128'd0;
  assign out_last  = out_valid ? mem_q[rd_ptr_q][128]   : 1'b0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {row_last, aligned_dat};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    rows_target_d = rows_target_q;
    row_cnt_d     = row_cnt_q;
    overflow_d    = overflow_q | drop;
    skew_err_d    = skew_err_q | row_skew;
    done_d        = 1'b0;
    if (row_form) begin
      row_cnt_d = row_cnt_q + ROWS_W'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (drain_start) begin
          rows_target_d = drain_rows;
          row_cnt_d     = '0;
          overflow_d    = 1'b0;
          skew_err_d    = 1'b0;
          state_d       = (drain_rows == '0) ? ST_FLUSH : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (row_cnt_q == rows_target_q) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (count_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rows_target_q <= '0;
      row_cnt_q     <= '0;
      overflow_q    <= 1'b0;
      skew_err_q    <= 1'b0;
      done_q        <= 1'b0;
      c1_dat_q      <= '0;
      c1_vld_q      <= '0;
      c2_dat_q      <= '0;
      c2_vld_q      <= '0;
      c3_dat_q      <= '0;
      c3_vld_q      <= 1'b0;
      mem_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      rows_target_q <= rows_target_d;
      row_cnt_q     <= row_cnt_d;
      overflow_q    <= overflow_d;
      skew_err_q    <= skew_err_d;
      done_q        <= done_d;
      c1_dat_q      <= c1_dat_d;
      c1_vld_q      <= c1_vld_d;
      c2_dat_q      <= c2_dat_d;
      c2_vld_q      <= c2_vld_d;
      c3_dat_q      <= c3_dat_d;
      c3_vld_q      <= c3_vld_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign skew_err = skew_err_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_drain.sv
`default_nettype none
// tb_systolic_drain: directed drains checked every cycle against a
// row-level queue model, plus literal expectations on popped rows.
module tb_systolic_drain;
  localparam int DEPTH  = 8;
  localparam int ROWS_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       din [4];
  logic              vin [4];
  logic              drain_start = 1'b0;
  logic [ROWS_W-1:0] drain_rows = '0;
  logic              out_ready = 1'b0;
  logic [127:0]      out_data;
  logic              out_valid, out_last, busy, done, overflow, skew_err;

  always #5 clk = ~clk;

  systolic_drain #(.DEPTH(DEPTH), .ROWS_W(ROWS_W)) dut (
    .clk(clk), .rst(rst),
    .sys_data_out_41(din[0]), .sys_data_out_42(din[1]),
    .sys_data_out_43(din[2]), .sys_data_out_44(din[3]),
    .sys_valid_out_41(vin[0]), .sys_valid_out_42(vin[1]),
    .sys_valid_out_43(vin[2]), .sys_valid_out_44(vin[3]),
    .drain_start(drain_start), .drain_rows(drain_rows),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done),
    .overflow(overflow), .skew_err(skew_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] row_word(input int tag, input int r);
    logic [127:0] w;
    for (int k = 0; k < 4; k++) w[32*k +: 32] = 32'((tag + r) * 256 + (k + 1) * 17);
    return w;
  endfunction

  // ---------------- model: per-edge input history + row queue ----------------
  logic [31:0]  hd [4][8];
  logic         hv [4][8];
  int           cyc = 0;
  logic [128:0] mq [$];
  int           m_state = 0;   // 0 idle, 1 collect, 2 flush
  int           m_target = 0, m_cnt = 0;
  logic         m_ovf = 1'b0, m_skew = 1'b0, m_done = 1'b0;
  int           pre_size, pre_state, pre_cnt;
  logic         m_pop;
  logic [3:0]   av;
  logic [127:0] ad;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_state = 0; m_target = 0; m_cnt = 0;
      m_ovf = 1'b0; m_skew = 1'b0; m_done = 1'b0;
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < 8; j++) begin hv[k][j] = 1'b0; hd[k][j] = '0; end
    end else begin
      for (int k = 0; k < 4; k++) begin
        hv[k][3'(cyc)] = vin[k];
        hd[k][3'(cyc)] = din[k];
      end
      // A row is column 1 from three edges ago through column 4 at this edge.
      for (int k = 0; k < 4; k++) begin
        av[k]         = hv[k][3'(cyc - 3 + k)];
        ad[32*k +: 32] = hd[k][3'(cyc - 3 + k)];
      end
      pre_size  = mq.size();
      pre_state = m_state;
      pre_cnt   = m_cnt;
      m_pop     = (pre_size > 0) && out_ready;
      m_done    = 1'b0;
      if (m_pop) void'(mq.pop_front());
      if (pre_state == 1 && pre_cnt != m_target) begin
        if (av == 4'hF) begin
          if (pre_size < DEPTH || m_pop) mq.push_back({(pre_cnt + 1 == m_target), ad});
          else m_ovf = 1'b1;
          m_cnt++;
        end else if (av != 4'h0) begin
          m_skew = 1'b1;
        end
      end
      case (pre_state)
        0: if (drain_start) begin
             m_target = int'(drain_rows); m_cnt = 0; m_ovf = 1'b0; m_skew = 1'b0;
             m_state = (drain_rows == '0) ? 2 : 1;
           end
        1: if (pre_cnt == m_target) m_state = 2;
        2: if (pre_size == 0) begin m_state = 0; m_done = 1'b1; end
        default: m_state = 0;
      endcase
      cyc++;
    end
  end

  // ---------------- compare + pop log ----------------
  logic         h_valid = 1'b0;
  logic [128:0] h_row = '0;
  logic [128:0] got [$];
  int           done_cnt = 0;

  always @(negedge clk) begin
    h_valid = out_valid;
    h_row   = {out_last, out_data};
    if (!rst) begin
      chk("out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("head_data", out_data, mq[0][127:0]);
        chk("head_last", out_last, mq[0][128]);
      end
      chk("busy", busy, m_state != 0);
      chk("done", done, m_done);
      chk("overflow", overflow, m_ovf);
      chk("skew_err", skew_err, m_skew);
      if (done) done_cnt++;
    end
  end

  always @(posedge clk) if (!rst && h_valid && out_ready) got.push_back(h_row);

  // ---------------- stimulus ----------------
  task automatic start_drain(input int rows);
    @(negedge clk);
    drain_start = 1'b1;
    drain_rows  = ROWS_W'(rows);
    @(negedge clk);
    drain_start = 1'b0;
  endtask

  // Row r reaches column k at cycle r+k (one extra cycle on skewcol).
  task automatic stream(input int nrows, input int tag, input int skewcol);
    int r;
    for (int c = 0; c < nrows + 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        r = c - k - ((k == skewcol) ? 1 : 0);
        vin[k] = (r >= 0) && (r < nrows);
        din[k] = vin[k] ? 32'((tag + r) * 256 + (k + 1) * 17) : 32'd0;
      end
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin vin[k] = 1'b0; din[k] = '0; end
  endtask

  task automatic wait_done(input string nm, input int budget, output int waited);
    waited = 0;
    while (waited < budget) begin
      @(negedge clk);
      waited++;
      if (done) break;
    end
    chk({nm, "_done_seen"}, done, 1'b1);
    @(negedge clk);
    chk({nm, "_done_width"}, done, 1'b0);
  endtask

  initial begin
    int w, dc0;
    for (int k = 0; k < 4; k++) begin vin[k] = 1'b0; din[k] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_skew_err", skew_err, 1'b0);
    chk("rst_out_data", out_data, 128'd0);
    #2 rst = 1'b0;

    // single row
    got.delete(); dc0 = done_cnt; out_ready = 1'b1;
    start_drain(1);
    stream(1, 0, -1);
    wait_done("single", 40, w);
    chk("single_pops", got.size(), 1);
    if (got.size() > 0) chk("single_row", got[0], {1'b1, 128'h00000044_00000033_00000022_00000011});
    chk("single_done_once", done_cnt - dc0, 1);
    chk("single_ovf", overflow, 1'b0);

    // backpressure
    got.delete(); dc0 = done_cnt; out_ready = 1'b0;
    start_drain(4);
    stream(4, 1, -1);
    chk("bp_valid_held", out_valid, 1'b1);
    chk("bp_model_rows", mq.size(), 4);
    repeat (2) @(negedge clk);
    chk("bp_no_pops", got.size(), 0);
    out_ready = 1'b1;
    wait_done("bp", 40, w);
    chk("bp_pops", got.size(), 4);
    for (int r = 0; r < 4 && r < got.size(); r++)
      chk("bp_row", got[r], {(r == 3), row_word(1, r)});
    if (got.size() == 4) chk("bp_row4_lit", got[3], {1'b1, 128'h00000444_00000433_00000422_00000411});
    chk("bp_done_once", done_cnt - dc0, 1);

    // overflow
    got.delete(); dc0 = done_cnt; out_ready = 1'b0;
    start_drain(10);
    stream(10, 16, -1);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_model_rows", mq.size(), 8);
    out_ready = 1'b1;
    wait_done("ovf", 60, w);
    chk("ovf_pops", got.size(), 8);
    for (int r = 0; r < 8 && r < got.size(); r++)
      chk("ovf_row", got[r], {1'b0, row_word(16, r)});
    if (got.size() == 8) chk("ovf_row8_lit", got[7], {1'b0, 128'h00001744_00001733_00001722_00001711});
    chk("ovf_sticky", overflow, 1'b1);
    chk("ovf_done_once", done_cnt - dc0, 1);

    // skew fault then a clean row
    got.delete(); out_ready = 1'b1;
    start_drain(1);
    stream(1, 32, 1);
    repeat (3) @(negedge clk);
    chk("skew_flag", skew_err, 1'b1);
    chk("skew_no_push", got.size(), 0);
    chk("skew_still_busy", busy, 1'b1);
    stream(1, 33, -1);
    wait_done("skew", 40, w);
    chk("skew_pops", got.size(), 1);
    if (got.size() > 0) chk("skew_row", got[0], {1'b1, 128'h00002144_00002133_00002122_00002111});
    chk("skew_sticky", skew_err, 1'b1);

    // reset mid-collect with two rows buffered
    out_ready = 1'b0;
    start_drain(3);
    stream(2, 48, -1);
    chk("mid_valid", out_valid, 1'b1);
    chk("mid_busy", busy, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_data", out_data, 128'd0);
    chk("mid_rst_last", out_last, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    got.delete(); out_ready = 1'b1;
    start_drain(1);
    stream(1, 64, -1);
    wait_done("post_rst", 40, w);
    chk("post_rst_pops", got.size(), 1);
    if (got.size() > 0) chk("post_rst_row", got[0], {1'b1, 128'h00004044_00004033_00004022_00004011});

    // zero-row drain, then valids while idle
    got.delete(); dc0 = done_cnt;
    start_drain(0);
    wait_done("zero", 10, w);
    chk("zero_latency", w, 1);
    stream(1, 80, -1);
    repeat (4) @(negedge clk);
    chk("zero_pops", got.size(), 0);
    chk("zero_busy", busy, 1'b0);
    chk("zero_skew", skew_err, 1'b0);
    chk("zero_done_once", done_cnt - dc0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/systolic_drain.md
# systolic_drain

Output collector for the 4x4 systolic array. It captures the four bottom-row partial-sum outputs, which arrive staggered by one cycle per column. It removes that skew so each result row becomes one 128-bit word, buffers the rows in a small FIFO, and hands them to the unified-buffer writer over a valid/ready handshake. The array cannot stall, so the block absorbs bursts and flags any loss or skew fault.

## Interface
- DEPTH, 8: FIFO depth in rows, power of two, at least 2.
- ROWS_W, 16: width of the row-count configuration.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- sys_data_out_41..44  in  32 each  bottom-row psums, columns 1..4.
- sys_valid_out_41..44  in  1 each  per-column valids. Column k valid lags column 1 by k-1 cycles.
- drain_start  in  1  one-cycle pulse that arms a drain. Sampled only in IDLE.
- drain_rows  in  ROWS_W  number of rows to collect; sampled with drain_start.
- out_data  out  128  head row; [31:0]=col1, [63:32]=col2, [95:64]=col3, [127:96]=col4.
- out_valid  out  1  FIFO non-empty.
- out_last  out  1  head row is row index drain_rows-1.
- out_ready  in  1  consumer accepts the head this cycle.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky: a row was dropped because the FIFO was full.
- skew_err  out  1  sticky: a row arrived with inconsistent valids.

## Operation
- States:
  - IDLE: on drain_start, load rows_target=drain_rows, clear row_cnt, overflow and skew_err. Go to COLLECT, or to FLUSH if drain_rows==0.
  - COLLECT: when row_cnt==rows_target, go to FLUSH.
  - FLUSH: when the FIFO is empty, go to IDLE and pulse done.
  - drain_start outside IDLE is ignored.
- Deskew: column k data and valid pass through a (4-k)-stage register delay line, so col1 is delayed 3 cycles, col2 2, col3 1 and col4 0. The four aligned valids are then compared.
  - All four valids high: an aligned row is formed.
  - Some but not all high: set skew_err and drop the row; row_cnt does not advance.
  - All low: nothing happens.
- Input valids are ignored outside COLLECT. Delay lines keep shifting in every state.
- Each aligned row formed in COLLECT increments row_cnt, whether it is stored or dropped. The row is tagged last when row_cnt==rows_target-1 at formation.
- FIFO:
  - Push an aligned row in COLLECT if count<DEPTH, or if count==DEPTH and a pop happens in the same cycle.
  - Otherwise drop the row and set overflow.
  - Pop happens when out_valid && out_ready.
  - Head is first-word fall-through. out_data and out_last hold stable while out_valid && !out_ready.
  - Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Simultaneous push and pop at count 0 is impossible, because out_valid is low at count 0.
- Rows collected beyond rows_target are impossible, because COLLECT exits when row_cnt reaches rows_target.

## Timing
- Reset (async, immediate): state IDLE, FIFO empty, delay lines and row_cnt cleared. All outputs are 0: out_data, out_valid, out_last, busy, done, overflow and skew_err. Reset mid-drain discards all buffered rows.
- Latency: col1 valid sampled at edge t, col4 valid sampled at edge t+3. The row is pushed at edge t+3, so out_valid is high in the cycle after edge t+3.
- Throughput: one row per cycle in, one row per cycle out.
- busy rises the cycle after drain_start.
- done is high exactly one cycle: the first cycle with busy=0, after the edge where FLUSH observes an empty FIFO.
- drain_rows==0: done in the second cycle after drain_start, with no out_valid.

## Test plan
- Single row:
  - Stimulus: drain_rows=1, out_ready=1. col1=0x11 at t, col2=0x22 at t+1, col3=0x33 at t+2, col4=0x44 at t+3.
  - Response: one cycle with out_valid=1, out_data=0x00000044_00000033_00000022_00000011, out_last=1. done pulses afterward; overflow=0, skew_err=0.
- Backpressure:
  - Stimulus: drain_rows=4, rows streamed back to back with values 1..4, out_ready=0 until busy has seen count=4, then out_ready=1.
  - Response: four pops in order 1,2,3,4, with out_last only on row 4. done pulses once after the 4th pop.
- Overflow:
  - Stimulus: DEPTH=8, drain_rows=10, out_ready=0 through collection.
  - Response: overflow=1 and 8 rows are held. Rows 1..8 drain in order, none with out_last. done pulses after the 8th pop.
- Skew fault:
  - Stimulus: col2 valid one cycle late.
  - Response: skew_err=1, no push, row_cnt unchanged. A following correct row is accepted.
- Reset mid-operation:
  - Stimulus: assert rst with 2 rows buffered and state COLLECT.
  - Response: out_valid, busy and flags go to 0 immediately. After release, a new drain_start works normally.
- Zero-row drain:
  - Stimulus: drain_start with drain_rows=0.
  - Response: done pulses, no out_valid; input valids are ignored.
